// File: rtl/if_window_addr_gen.sv
// Sliding-window read-address generator for the IF scratchpad (circular row buffer).
// Optional build macro IF_DILATION_EN adds the dilation port and a dilated in-window step.
module if_window_addr_gen #(
    parameter int POINTER_SIZE         = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int STRIDE_SIZE          = 3,
    parameter int DILATION_SIZE        = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic [STRIDE_SIZE-1:0]          stride,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
`ifdef IF_DILATION_EN
    input  logic [DILATION_SIZE-1:0]        dilation,
`endif
    input  logic [POINTER_SIZE-1:0]         start_row,
    input  logic [POINTER_SIZE-1:0]         end_row,
    input  logic                            next_row,
    input  logic                            addr_ready,
    output logic [POINTER_SIZE-1:0]         read_pointer,
    output logic                            addr_valid,
    output logic                            window_last,
    output logic                            row_done,
    output logic                            busy
);
    localparam int PW = POINTER_SIZE;
    localparam int FW = FILTER_SIZE_REG_SIZE;
    localparam int SW = STRIDE_SIZE;
    localparam int DW = DILATION_SIZE;
    localparam int MW = FW + DW;
    localparam int XW = PW + FW + DW;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_ROW} state_t;

    state_t        state, state_n;
    logic [PW-1:0] offset, offset_n, start_q, start_n, end_q, end_n;
    logic [FW-1:0] counter, counter_n, fsize_q, fsize_n, fsize_in;
    logic [SW-1:0] stride_q, stride_n, stride_in;
    logic          row_done_q, row_done_n;
    logic [MW-1:0] span_in, span_q, elem_off;
    logic [PW-1:0] len_in, len_q, rel_q;
    logic [XW-1:0] rel_next;
    logic          last_elem;

    // Fit test is done wide so rel + span can never wrap back into range
    function automatic logic fits(input logic [XW-1:0] rel, input logic [MW-1:0] span,
                                  input logic [PW-1:0] len);
        return (rel + XW'(span)) <= XW'(len);
    endfunction

    assign fsize_in  = (filter_size == '0) ? FW'(1) : filter_size;
    assign stride_in = (stride == '0) ? SW'(1) : stride;

`ifdef IF_DILATION_EN
    logic [DW-1:0] step_q, step_n, step_in;
    assign step_in  = (dilation == '0) ? DW'(1) : dilation;
    assign span_in  = MW'(fsize_in - FW'(1)) * MW'(step_in);
    assign span_q   = MW'(fsize_q - FW'(1)) * MW'(step_q);
    assign elem_off = MW'(counter) * MW'(step_q);
`else
    assign span_in  = MW'(fsize_in - FW'(1));
    assign span_q   = MW'(fsize_q - FW'(1));
    assign elem_off = MW'(counter);
`endif

    // Differences are kept at pointer width so the circular buffer wraps naturally
    assign len_in    = end_row - start_row;
    assign len_q     = end_q - start_q;
    assign rel_q     = offset - start_q;
    assign rel_next  = XW'(rel_q) + XW'(stride_q);
    assign last_elem = (counter >= (fsize_q - FW'(1)));

    assign read_pointer = offset + PW'(elem_off);
    assign addr_valid   = (state == RUN);
    assign window_last  = (state == RUN) && last_elem;
    assign row_done     = row_done_q;
    assign busy         = (state != IDLE);

    always_comb begin
        state_n    = state;
        offset_n   = offset;
        counter_n  = counter;
        start_n    = start_q;
        end_n      = end_q;
        fsize_n    = fsize_q;
        stride_n   = stride_q;
        row_done_n = 1'b0;
`ifdef IF_DILATION_EN
        step_n     = step_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    fsize_n   = fsize_in;
                    stride_n  = stride_in;
`ifdef IF_DILATION_EN
                    step_n    = step_in;
`endif
                    start_n   = start_row;
                    end_n     = end_row;
                    offset_n  = start_row;
                    counter_n = '0;
                    if (fits('0, span_in, len_in)) begin
                        state_n = RUN;
                    end else begin
                        row_done_n = 1'b1;
                        state_n    = WAIT_ROW;
                    end
                end
            end
            RUN: begin
                if (addr_ready) begin
                    if (!last_elem) begin
                        counter_n = counter + FW'(1);
                    end else begin
                        counter_n = '0;
                        if (fits(rel_next, span_q, len_q)) begin
                            offset_n = offset + PW'(stride_q);
                        end else begin
                            row_done_n = 1'b1;
                            state_n    = WAIT_ROW;
                        end
                    end
                end
            end
            WAIT_ROW: begin
                if (next_row) begin
                    start_n   = start_row;
                    end_n     = end_row;
                    offset_n  = start_row;
                    counter_n = '0;
                    if (fits('0, span_q, len_in)) begin
                        state_n = RUN;
                    end else begin
                        row_done_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop) begin
            state_n    = IDLE;
            row_done_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            offset     <= '0;
            counter    <= '0;
            start_q    <= '0;
            end_q      <= '0;
            fsize_q    <= '0;
            stride_q   <= '0;
            row_done_q <= 1'b0;
`ifdef IF_DILATION_EN
            step_q     <= '0;
`endif
        end else begin
            state      <= state_n;
            offset     <= offset_n;
            counter    <= counter_n;
            start_q    <= start_n;
            end_q      <= end_n;
            fsize_q    <= fsize_n;
            stride_q   <= stride_n;
            row_done_q <= row_done_n;
`ifdef IF_DILATION_EN
            step_q     <= step_n;
`endif
        end
    end
endmodule

// File: doc/if_window_addr_gen.md
Name: if_window_addr_gen

Overview:
Parametrised read-address generator for the input-feature (IF) scratchpad in the convolution datapath. It walks sliding filter windows across one buffered IF row at a programmable stride, issuing one element address per accepted beat on a valid/ready handshake toward the IF read port. It detects end-of-row internally from row bounds, so no external end_of_row signal is needed. The row pointers address a circular buffer with modulo-2^POINTER_SIZE wrap.

Parameters:
POINTER_SIZE, 8, width of buffer pointers; buffer depth is 2^POINTER_SIZE.
FILTER_SIZE_REG_SIZE, 8, width of filter_size and the in-window element counter.
STRIDE_SIZE, 3, width of stride.
DILATION_SIZE, 3, width of dilation; the dilation port exists only with IF_DILATION_EN.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse, sampled in IDLE; latches configuration and the first row.
stop  in  1  abort; returns the block to IDLE from any state.
stride  in  STRIDE_SIZE  window step; latched at start.
filter_size  in  FILTER_SIZE_REG_SIZE  elements per window; latched at start.
dilation  in  DILATION_SIZE  element step inside a window (IF_DILATION_EN only); latched at start.
start_row  in  POINTER_SIZE  pointer to the first element of the row; latched at start or next_row.
end_row  in  POINTER_SIZE  pointer to the last element of the row (inclusive); latched with start_row.
next_row  in  1  pulse, sampled in WAIT_ROW: a new row is ready in the buffer.
addr_ready  in  1  consumer accepts read_pointer.
read_pointer  out  POINTER_SIZE  element address.
addr_valid  out  1  read_pointer is valid.
window_last  out  1  the current beat is the last element of a window.
row_done  out  1  one-cycle pulse: no further window fits in the current row.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs are 0. State = IDLE; offset, counter and latched configuration are 0.
- Sanitising: filter_size of 0 is treated as 1; stride of 0 is treated as 1; step is 1 (or the dilation, with 0 treated as 1).
- Derived values (all mod 2^POINTER_SIZE):
  - span = (filter_size-1)*step
  - len = end_row - start_row
  - rel = offset - start_row
  - A window at rel fits iff rel + span <= len; compute rel + span at POINTER_SIZE+FILTER_SIZE_REG_SIZE+DILATION_SIZE bits with no truncation.
- read_pointer = offset + counter*step, truncated to POINTER_SIZE bits (natural wrap).
- States: IDLE, RUN, WAIT_ROW.
- IDLE, on start: latch configuration and row bounds; offset <= start_row; counter <= 0.
  - If the window at rel = 0 fits, go to RUN; addr_valid rises the next cycle (1-cycle latency).
  - Otherwise pulse row_done and go to WAIT_ROW.
- RUN: addr_valid = 1. read_pointer, addr_valid and window_last are held stable while addr_ready = 0.
- RUN, on each accepted beat (addr_valid and addr_ready):
  - If counter < filter_size-1: counter++.
  - Else: window_last was high on this beat; counter <= 0.
    - If the window at rel + stride fits: offset += stride.
    - Else: row_done pulses in the next cycle, addr_valid drops, go to WAIT_ROW.
- WAIT_ROW: addr_valid = 0.
  - On next_row: latch start_row/end_row, offset <= start_row, counter <= 0, then apply the same fit check as for start.
  - A row shorter than span+1 gives a row_done pulse with zero beats, and the block stays in WAIT_ROW.
- stop:
  - Has priority over every other event; next state is IDLE and addr_valid is 0 next cycle.
  - A beat accepted in the same cycle counts as delivered, but no further beats follow.
- start outside IDLE and next_row outside WAIT_ROW are ignored.
- Reset mid-operation: immediate return to the reset values.

Optional Feature:
IF_DILATION_EN:
- Defined: the dilation port exists and step = dilation (0 treated as 1).
- Undefined: the port is absent, step is 1, and the multiplier is removed (read_pointer = offset + counter).

Test Plan:
1. Basic row: start_row=10, end_row=17, filter_size=3, stride=2, addr_ready=1 -> read_pointer sequence 10,11,12,12,13,14,14,15,16; window_last on beats 3, 6 and 9; row_done one cycle after beat 9.
2. Wrap: start_row=250, end_row=3, filter_size=4, stride=3 -> addresses 250,251,252,253, 253,254,255,0, 0,1,2,3; then row_done.
3. Backpressure and next_row:
   - Hold addr_ready=0 for 3 cycles mid-window -> read_pointer and window_last stay constant.
   - next_row with start_row=20, end_row=24, filter_size=5 -> exactly one window, 20..24.
4. Short row: filter_size=5, start_row=0, end_row=2 -> row_done pulse, addr_valid never rises, state WAIT_ROW.
5. Stop and reset:
   - stop asserted together with the 4th accepted beat -> addr_valid=0 and busy=0 next cycle.
   - rst low mid-RUN -> all outputs 0 immediately.
6. IF_DILATION_EN: dilation=2, filter_size=3, stride=1, start_row=0, end_row=9 -> windows 0,2,4 / 1,3,5 / ... / 5,7,9 (6 windows), then row_done.
